mutex_bank: RTL and testbench



---
 rtl/mutex_bank_pkg.sv | 20 ++
 rtl/mutex_bank_cell.sv | 105 ++++++++++
 rtl/mutex_bank.sv | 96 +++++++++
 tb/tb_mutex_bank.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mutex_bank_pkg.sv
// Shared constants and elaboration-time helpers for the mutex bank.
// Register selects, LEASE status bit positions and the derived widths.
package mutex_bank_pkg;

   localparam logic REG_MUTEX = 1'b0;
   localparam logic REG_LEASE = 1'b1;

   localparam int RESET_FLAG_BIT = 31;
   localparam int EXPIRED_BIT    = 30;

   // Address is {mutex index, register select}; a single mutex needs only the select bit.
   function automatic int calc_aw(input int num_mutex);
      return $clog2(num_mutex) + 1;
   endfunction

   function automatic int calc_ps_w(input int prescale);
      return (prescale > 1) ? $clog2(prescale) : 1;
   endfunction

endpackage

// File: rtl/mutex_bank_cell.sv
// One hardware mutex: owner/value lock with a lease countdown that
// auto-releases the lock and raises a sticky expired flag.
module mutex_bank_cell
   import mutex_bank_pkg::*;
#(
   parameter int VALUE_W = 16,
   parameter int OWNER_W = 16,
   parameter int LEASE_W = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        mutex_we,
   input  logic        lease_we,
   input  logic        tick,
   input  logic        reg_sel,
   input  logic [31:0] writedata,
   output logic [31:0] rdata,
   output logic        expired,
   output logic        locked
);

   logic [VALUE_W-1:0] value_q, value_d;
   logic [OWNER_W-1:0] owner_q, owner_d;
   logic [LEASE_W-1:0] lease_len_q, lease_len_d;
   logic [LEASE_W-1:0] count_q, count_d;
   logic               expired_q, expired_d;
   logic               reset_flag_q, reset_flag_d;

   logic [OWNER_W-1:0] wr_own;
   logic [VALUE_W-1:0] wr_val;
   logic               wr_en;
   logic               dec;
   logic               expire;

   assign wr_own = writedata[31:VALUE_W];
   assign wr_val = writedata[VALUE_W-1:0];

   // Free mutex, or the current owner acquiring/renewing/releasing.
   assign wr_en  = mutex_we && ((value_q == '0) || (owner_q == wr_own));
   assign dec    = tick && (value_q != '0) && (lease_len_q != '0) && (count_q != '0);
   assign expire = dec && (count_q == LEASE_W'(1));

   always_comb begin
      value_d      = value_q;
      owner_d      = owner_q;
      lease_len_d  = lease_len_q;
      count_d      = count_q;
      expired_d    = expired_q;
      reset_flag_d = reset_flag_q;

      if (dec) begin
         count_d = count_q - 1'b1;
      end
      if (expire) begin
         value_d = '0;
      end

      // A same-cycle owner write overrides the timeout entirely.
      if (wr_en) begin
         value_d = wr_val;
         owner_d = wr_own;
         count_d = (wr_val != '0) ? lease_len_q : '0;
      end

      if (lease_we) begin
         lease_len_d = writedata[LEASE_W-1:0];
         if (writedata[RESET_FLAG_BIT]) begin
            reset_flag_d = 1'b0;
         end
         if (writedata[EXPIRED_BIT]) begin
            expired_d = 1'b0;
         end
      end

      // Set after the clear so a new expiry beats a concurrent clear.
      if (expire && !wr_en) begin
         expired_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         value_q      <= '0;
         owner_q      <= '0;
         lease_len_q  <= '0;
         count_q      <= '0;
         expired_q    <= 1'b0;
         reset_flag_q <= 1'b1;
      end else begin
         value_q      <= value_d;
         owner_q      <= owner_d;
         lease_len_q  <= lease_len_d;
         count_q      <= count_d;
         expired_q    <= expired_d;
         reset_flag_q <= reset_flag_d;
      end
   end

   assign rdata   = (reg_sel == REG_LEASE)
                  ? {reset_flag_q, expired_q, {(30-LEASE_W){1'b0}}, count_q}
                  : {owner_q, value_q};
   assign expired = expired_q;
   assign locked  = (value_q != '0);

endmodule

// File: rtl/mutex_bank.sv
// Avalon-MM bank of NUM_MUTEX lease-timed hardware mutexes: address decode,
// shared lease prescaler, zero-wait readdata mux, irq and locked status.
module mutex_bank
   import mutex_bank_pkg::*;
#(
   parameter int NUM_MUTEX = 8,
   parameter int VALUE_W   = 16,
   parameter int OWNER_W   = 16,
   parameter int LEASE_W   = 16,
   parameter int PRESCALE  = 1000,
   parameter int AW        = calc_aw(NUM_MUTEX)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 chipselect,
   input  logic [AW-1:0]        address,
   input  logic                 read,
   input  logic                 write,
   input  logic [31:0]          writedata,
   output logic [31:0]          readdata,
   output logic                 irq,
   output logic [NUM_MUTEX-1:0] locked
);

   localparam int              PS_W   = calc_ps_w(PRESCALE);
   localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

   logic [AW-1:0]        idx;
   logic                 idx_ok;
   logic                 reg_sel;
   logic                 wr_strobe;
   logic [NUM_MUTEX-1:0] hit;
   logic [NUM_MUTEX-1:0] expired_vec;
   logic [31:0]          cell_rdata [NUM_MUTEX];

   logic [PS_W-1:0]      presc_q, presc_d;
   logic                 tick;
   logic                 irq_q, irq_d;

   // Reads are side-effect free, so the strobe is not needed for decode.
   logic                 unused_read;
   assign unused_read = read;

   assign idx       = address >> 1;
   assign idx_ok    = (32'(idx) < NUM_MUTEX);
   assign reg_sel   = address[0];
   assign wr_strobe = chipselect && write;

   for (genvar i = 0; i < NUM_MUTEX; i++) begin : g_cell
      assign hit[i] = idx_ok && (idx == AW'(i));

      mutex_bank_cell #(
         .VALUE_W (VALUE_W),
         .OWNER_W (OWNER_W),
         .LEASE_W (LEASE_W)
      ) u_cell (
         .clk       (clk),
         .reset_n   (reset_n),
         .mutex_we  (wr_strobe && hit[i] && (reg_sel == REG_MUTEX)),
         .lease_we  (wr_strobe && hit[i] && (reg_sel == REG_LEASE)),
         .tick      (tick),
         .reg_sel   (reg_sel),
         .writedata (writedata),
         .rdata     (cell_rdata[i]),
         .expired   (expired_vec[i]),
         .locked    (locked[i])
      );
   end

   always_comb begin
      readdata = '0;
      for (int i = 0; i < NUM_MUTEX; i++) begin
         if (hit[i]) begin
            readdata = cell_rdata[i];
         end
      end
   end

   // One shared free-running prescaler paces every lease counter.
   assign tick    = (presc_q == PS_MAX);
   assign presc_d = tick ? '0 : presc_q + 1'b1;
   assign irq_d   = |expired_vec;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc_q <= '0;
         irq_q   <= 1'b0;
      end else begin
         presc_q <= presc_d;
         irq_q   <= irq_d;
      end
   end

   assign irq = irq_q;

endmodule

// File: tb/tb_mutex_bank.sv
// Directed plus randomized bench for mutex_bank with a behavioural model
// of the mutex/lease rules kept as plain per-mutex arrays.
module tb_mutex_bank;

   localparam int N  = 5;
   localparam int P  = 4;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          chipselect;
   logic [AW-1:0] address;
   logic          read;
   logic          write;
   logic [31:0]   writedata;
   logic [31:0]   readdata;
   logic          irq;
   logic [N-1:0]  locked;

   int errors = 0;
   int total  = 0;

   // Behavioural model state
   int unsigned m_val [N];
   int unsigned m_own [N];
   int unsigned m_len [N];
   int unsigned m_cnt [N];
   bit          m_exp [N];
   bit          m_rf  [N];
   int          m_ps;
   bit          m_irq;

   mutex_bank #(
      .NUM_MUTEX (N),
      .VALUE_W   (16),
      .OWNER_W   (16),
      .LEASE_W   (16),
      .PRESCALE  (P)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .chipselect (chipselect),
      .address    (address),
      .read       (read),
      .write      (write),
      .writedata  (writedata),
      .readdata   (readdata),
      .irq        (irq),
      .locked     (locked)
   );

   always #50 clk = ~clk;

   initial begin
      #20000000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [AW-1:0] A(input int idx, input int r);
      return AW'((idx << 1) | r);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_val[i] = 0; m_own[i] = 0; m_len[i] = 0; m_cnt[i] = 0;
         m_exp[i] = 0; m_rf[i] = 1;
      end
      m_ps  = 0;
      m_irq = 0;
   endtask

   function automatic logic [31:0] model_read(input logic [AW-1:0] a);
      int idx = int'(a >> 1);
      if (idx >= N) return 32'h0;
      if (a[0]) return {m_rf[idx], m_exp[idx], 14'h0, 16'(m_cnt[idx])};
      return {16'(m_own[idx]), 16'(m_val[idx])};
   endfunction

   function automatic logic [N-1:0] model_locked();
      logic [N-1:0] v = '0;
      for (int i = 0; i < N; i++) v[i] = (m_val[i] != 0);
      return v;
   endfunction

   // Advance the model by one clock edge using the bus values presented now.
   task automatic model_edge();
      bit          t    = (m_ps == P - 1);
      int          idx  = int'(address >> 1);
      bit          hit  = chipselect && write && (idx < N);
      bit          nirq = 0;
      int unsigned own  = writedata >> 16;
      int unsigned v    = writedata & 32'hFFFF;
      for (int i = 0; i < N; i++) nirq |= m_exp[i];
      for (int i = 0; i < N; i++) begin
         int unsigned v0  = m_val[i];
         bit          dec = t && m_val[i] != 0 && m_len[i] != 0 && m_cnt[i] != 0;
         bit          ex  = dec && m_cnt[i] == 1;
         if (dec) m_cnt[i] = m_cnt[i] - 1;
         if (ex)  m_val[i] = 0;
         if (hit && idx == i && !address[0] && (v0 == 0 || m_own[i] == own)) begin
            m_val[i] = v;
            m_own[i] = own;
            m_cnt[i] = (v != 0) ? m_len[i] : 0;
            ex = 0;
         end
         if (hit && idx == i && address[0]) begin
            m_len[i] = v;
            if (writedata[31]) m_rf[i]  = 0;
            if (writedata[30]) m_exp[i] = 0;
         end
         if (ex) m_exp[i] = 1;
      end
      m_ps  = (m_ps + 1) % P;
      m_irq = nirq;
   endtask

   task automatic cyc();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc();
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write = 1'b1;
      cyc();
      chipselect = 1'b0; write = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic rd(input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
      address = a; chipselect = 1'b1; read = 1'b1;
      #1;
      chk(tag, readdata, exp);
      chipselect = 1'b0; read = 1'b0;
   endtask

   task automatic rd_mdl(input string tag, input logic [AW-1:0] a);
      rd(tag, a, model_read(a));
   endtask

   task automatic align_tick();
      while (m_ps != P - 1) cyc();
   endtask

   initial begin
      logic [31:0] d;
      int          ri;
      bit          rr;

      reset_n = 1'b0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
      address = '0; writedata = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_irq", 32'(irq), 32'h0);
      chk("rst_locked", 32'(locked), 32'h0);
      reset_n = 1'b1;

      // Reset flag behaviour
      rd("rst_lease0", A(0, 1), 32'h8000_0000);
      rd("rst_mutex0", A(0, 0), 32'h0);
      wr(A(0, 1), 32'h8000_0000);
      rd("rf_clear0", A(0, 1), 32'h0000_0000);
      rd("rf_keep1", A(1, 1), 32'h8000_0000);

      // Owner semantics
      wr(A(3, 0), 32'h0001_0005);
      rd("acq3", A(3, 0), 32'h0001_0005);
      chk("locked3_on", 32'(locked[3]), 32'h1);
      wr(A(3, 0), 32'h0002_0007);
      rd("foreign3", A(3, 0), 32'h0001_0005);
      wr(A(3, 0), 32'h0001_0000);
      rd("rel3", A(3, 0), 32'h0001_0000);
      chk("locked3_off", 32'(locked[3]), 32'h0);

      // Lease expiry: acquire on a tick edge so expiry lands 12 edges later
      wr(A(2, 1), 32'h0000_0003);
      align_tick();
      wr(A(2, 0), 32'h00AA_0001);
      idle(10);
      rd("pre_exp_cnt", A(2, 1), 32'h8000_0001);
      cyc();
      rd("pre_exp_val", A(2, 0), 32'h00AA_0001);
      cyc();
      rd("exp_val", A(2, 0), 32'h00AA_0000);
      rd("exp_lease", A(2, 1), 32'hC000_0000);
      chk("exp_locked", 32'(locked[2]), 32'h0);
      chk("irq_lag", 32'(irq), 32'h0);
      cyc();
      chk("irq_set", 32'(irq), 32'h1);
      wr(A(2, 1), 32'h4000_0003);
      rd("exp_clr", A(2, 1), 32'h8000_0000);
      cyc();
      chk("irq_clr", 32'(irq), 32'h0);

      // Renewal on the expiring tick wins over expiry
      align_tick();
      wr(A(2, 0), 32'h00AA_0001);
      idle(11);
      wr(A(2, 0), 32'h00AA_0002);
      rd("renew_val", A(2, 0), 32'h00AA_0002);
      rd("renew_lease", A(2, 1), 32'h8000_0003);
      cyc();
      chk("renew_irq", 32'(irq), 32'h0);
      wr(A(2, 0), 32'h00AA_0000);

      // No lease means no timeout
      wr(A(4, 0), 32'h0005_0009);
      idle(10000);
      rd("nolease_val", A(4, 0), 32'h0005_0009);
      rd("nolease_cnt", A(4, 1), 32'h8000_0000);
      chk("nolease_irq", 32'(irq), 32'h0);
      chk("nolease_locked", 32'(locked[4]), 32'h1);

      // Out-of-range index and writes without chipselect
      wr(A(6, 0), 32'h0001_0001);
      wr(A(6, 1), 32'hC000_0005);
      wr(A(7, 0), 32'h0002_0002);
      address = A(1, 0); writedata = 32'h0009_0009; write = 1'b1; chipselect = 1'b0;
      cyc();
      write = 1'b0;
      rd("oor_mutex", A(6, 0), 32'h0);
      rd("oor_lease", A(6, 1), 32'h0);
      rd("nocs_mutex1", A(1, 0), 32'h0);
      for (int i = 0; i < N; i++) begin
         rd_mdl($sformatf("oor_m%0d", i), A(i, 0));
         rd_mdl($sformatf("oor_l%0d", i), A(i, 1));
      end

      // Randomized traffic against the model
      for (int k = 0; k < 400; k++) begin
         ri = $urandom_range(0, 7);
         rr = 1'($urandom_range(0, 1));
         if (!rr) begin
            d[31:16] = 16'($urandom_range(1, 3));
            d[15:0]  = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom_range(1, 4));
         end else begin
            d        = '0;
            d[31]    = ($urandom_range(0, 7) == 0);
            d[30]    = ($urandom_range(0, 3) == 0);
            d[15:0]  = 16'($urandom_range(0, 4));
         end
         address    = A(ri, int'(rr));
         writedata  = d;
         chipselect = ($urandom_range(0, 7) != 0);
         write      = ($urandom_range(0, 2) != 0);
         cyc();
         chipselect = 1'b0; write = 1'b0;
         rd_mdl("rand_rd", A($urandom_range(0, 7), $urandom_range(0, 1)));
         chk("rand_irq", 32'(irq), 32'(m_irq));
         chk("rand_locked", 32'(locked), 32'(model_locked()));
      end

      // Asynchronous reset in the middle of a lease
      wr(A(1, 1), 32'h0000_0005);
      wr(A(1, 0), 32'h0003_0001);
      idle(5);
      #10;
      reset_n = 1'b0;
      model_reset();
      #2;
      for (int i = 0; i < N; i++) begin
         rd($sformatf("arst_m%0d", i), A(i, 0), 32'h0);
         rd($sformatf("arst_l%0d", i), A(i, 1), 32'h8000_0000);
      end
      chk("arst_irq", 32'(irq), 32'h0);
      chk("arst_locked", 32'(locked), 32'h0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      idle(30);
      rd("post_rst_m1", A(1, 0), 32'h0);
      rd("post_rst_l1", A(1, 1), 32'h8000_0000);
      chk("post_rst_irq", 32'(irq), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, total);
      $finish;
   end

endmodule
